// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and width limits
package gray_pkg;

    localparam int MAX_W = 32;
    localparam int MIN_W = 2;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_LOAD = 2'd3
    } step_e;

    // Narrower values are passed zero-extended; the upper zeros leave the low bits correct.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary_n.sv
// rtl/gray_to_binary_n.sv - combinational W-bit Gray-to-binary decoder
module gray_to_binary_n #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - W-bit up/down counter with registered Gray and binary outputs
module gray_counter_n #(
    parameter int          W            = 4,
    parameter int unsigned RESET_VAL    = 0,
    parameter bit          WRAP         = 1'b1,
    parameter bit          LOAD_IS_GRAY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] gray_out,
    output logic [W-1:0] bin_out,
    output logic         tc
);

    import gray_pkg::*;

    if (W < MIN_W || W > MAX_W) begin : g_bad_w
        $error("gray_counter_n: W out of range");
    end
    if ((64'(RESET_VAL) >> W) != 64'd0) begin : g_bad_rst
        $error("gray_counter_n: RESET_VAL does not fit in W bits");
    end

    localparam logic [W-1:0] RST_BIN  = W'(RESET_VAL);
    localparam logic [W-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic         r_tc;

    logic [W-1:0] w_load_bin;
    logic [W-1:0] w_bin_next;
    logic [W-1:0] w_gray_next;
    logic         w_tc_next;
    logic         w_at_max;
    logic         w_at_min;
    step_e        w_step;

    if (LOAD_IS_GRAY) begin : g_gray_load
        gray_to_binary_n #(.W(W)) u_load_dec (
            .i_gray (load_val),
            .o_bin  (w_load_bin)
        );
    end else begin : g_bin_load
        assign w_load_bin = load_val;
    end

    assign w_at_max = (r_bin == {W{1'b1}});
    assign w_at_min = (r_bin == {W{1'b0}});

    always_comb begin
        w_step = STEP_HOLD;
        if (load) begin
            w_step = STEP_LOAD;
        end else if (en) begin
            w_step = up_dn ? STEP_UP : STEP_DN;
        end
    end

    // tc flags any enabled step taken from a terminal state, whether it wraps or saturates.
    always_comb begin
        w_bin_next = r_bin;
        w_tc_next  = 1'b0;
        case (w_step)
            STEP_LOAD: w_bin_next = w_load_bin;
            STEP_UP: begin
                w_tc_next = w_at_max;
                if (WRAP || !w_at_max) begin
                    w_bin_next = r_bin + 1'b1;
                end
            end
            STEP_DN: begin
                w_tc_next = w_at_min;
                if (WRAP || !w_at_min) begin
                    w_bin_next = r_bin - 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_gray_next = W'(bin2gray(MAX_W'(w_bin_next)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= RST_BIN;
            r_gray <= RST_GRAY;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_tc   <= w_tc_next;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign tc       = r_tc;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - self-checking bench for gray_counter_n
module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [2:0][3:0] bin_o;
    logic [2:0][3:0] gray_o;
    logic [2:0]      tc_o;

    // Instance 0: wrap, binary load. 1: saturate, RESET_VAL=3. 2: wrap, Gray load.
    gray_counter_n #(.W(4), .RESET_VAL(0), .WRAP(1'b1), .LOAD_IS_GRAY(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .gray_out(gray_o[0]), .bin_out(bin_o[0]), .tc(tc_o[0]));
    gray_counter_n #(.W(4), .RESET_VAL(3), .WRAP(1'b0), .LOAD_IS_GRAY(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .gray_out(gray_o[1]), .bin_out(bin_o[1]), .tc(tc_o[1]));
    gray_counter_n #(.W(4), .RESET_VAL(0), .WRAP(1'b1), .LOAD_IS_GRAY(1'b1)) u_gld (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .gray_out(gray_o[2]), .bin_out(bin_o[2]), .tc(tc_o[2]));

    int n_cmp = 0;
    int n_bad = 0;

    int m_bin[3];
    int m_tc[3];
    int rv[3] = '{0, 3, 0};
    int wr[3] = '{1, 0, 1};
    int lg[3] = '{0, 0, 1};

    typedef struct {
        logic r, e, u, l;
        int   lv;
        int   exp_bin;
        int   exp_tc;
    } vec_t;
    vec_t tbl[$];

    function automatic int gray_of(int b);
        return b ^ (b >> 1);
    endfunction

    // The binary value whose Gray image is g, found by search.
    function automatic int gray_decode(int g);
        for (int b = 0; b < 16; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_bin[k] = rv[k];
                m_tc[k]  = 0;
            end else if (load) begin
                m_bin[k] = (lg[k] != 0) ? gray_decode(int'(load_val)) : int'(load_val);
                m_tc[k]  = 0;
            end else if (en) begin
                if (up_dn) begin
                    m_tc[k] = (m_bin[k] == 15) ? 1 : 0;
                    if (!(m_bin[k] == 15 && wr[k] == 0)) m_bin[k] = (m_bin[k] + 1) % 16;
                end else begin
                    m_tc[k] = (m_bin[k] == 0) ? 1 : 0;
                    if (!(m_bin[k] == 0 && wr[k] == 0)) m_bin[k] = (m_bin[k] + 15) % 16;
                end
            end else begin
                m_tc[k] = 0;
            end
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic u, input logic l, input int lv);
        int prev_g[3];
        @(negedge clk);
        rst = r; en = e; up_dn = u; load = l; load_val = 4'(lv);
        for (int k = 0; k < 3; k++) prev_g[k] = int'(gray_o[k]);
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bin[%0d]", k), int'(bin_o[k]), m_bin[k]);
            chk($sformatf("gray[%0d]", k), int'(gray_o[k]), gray_of(m_bin[k]));
            chk($sformatf("tc[%0d]", k), int'(tc_o[k]), m_tc[k]);
            if (!r && !l && e && wr[k] != 0) begin
                chk($sformatf("gray_one_bit[%0d]", k), $countones(4'(prev_g[k]) ^ gray_o[k]), 1);
            end
        end
    endtask

    function automatic void add(input logic r, input logic e, input logic u, input logic l,
                                input int lv, input int eb, input int et);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv; v.exp_bin = eb; v.exp_tc = et;
        tbl.push_back(v);
    endfunction

    initial begin
        // Expected values for the wrapping binary-load instance.
        add(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) add(1'b0, 1'b1, 1'b1, 1'b0, 0, k % 16, (k == 16) ? 1 : 0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 0, 15, 1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 0, 14, 0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 5, 5, 0);
        for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 9, 5, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
            chk($sformatf("tbl%0d_bin", i), int'(bin_o[0]), tbl[i].exp_bin);
            chk($sformatf("tbl%0d_gray", i), int'(gray_o[0]), gray_of(tbl[i].exp_bin));
            chk($sformatf("tbl%0d_tc", i), int'(tc_o[0]), tbl[i].exp_tc);
        end

        // Saturation at both ends on the non-wrapping instance.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 13);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("sat_reach_tc", int'(tc_o[1]), 0);
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
            chk("sat_hi_bin", int'(bin_o[1]), 15);
            chk("sat_hi_gray", int'(gray_o[1]), 4'b1000);
            chk("sat_hi_tc", int'(tc_o[1]), 1);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
            chk("sat_lo_bin", int'(bin_o[1]), 0);
            chk("sat_lo_tc", int'(tc_o[1]), 1);
        end

        // Gray-coded load, then one step up.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101);
        chk("gld_bin", int'(bin_o[2]), 9);
        chk("gld_gray", int'(gray_o[2]), 4'b1101);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("gld_step_bin", int'(bin_o[2]), 10);
        chk("gld_step_gray", int'(gray_o[2]), 4'b1111);

        // Direction reversal on consecutive cycles.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Reset wins over load and enable.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 11);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
        chk("pre_rst_bin", int'(bin_o[1]), 12);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 7);
        chk("mid_rst_bin", int'(bin_o[1]), 3);
        chk("mid_rst_gray", int'(gray_o[1]), 4'b0010);
        chk("mid_rst_tc", int'(tc_o[1]), 0);
        chk("mid_rst_bin0", int'(bin_o[0]), 0);

        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
